logic_gate_pipe: RTL

//   Parametrised, pipelined bitwise logic unit. Successor to the single 2-input AND gate.

---
 rtl/logic_gate_pipe_if.sv | 28 ++
 rtl/logic_gate_pipe.sv | 101 ++++++++++
 2 files changed

// File: rtl/logic_gate_pipe_if.sv
// Handshake bundle for logic_gate_pipe: input operands/op, result side and transfer counter.
// master drives operands and out_ready; slave (the pipe) drives results and in_ready.
interface logic_gate_pipe_if #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 2,
    parameter int CNT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              in_op;
    logic [N_IN*WIDTH-1:0]   in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_zero;
    logic                    out_err;
    logic [CNT_W-1:0]        done_cnt;

    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_err, done_cnt
    );

    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_err, done_cnt
    );
endinterface

// File: rtl/logic_gate_pipe.sv
// Two-stage bitwise logic unit over N_IN operands; result valid two edges after acceptance.
// Ready ripples combinationally from out_ready back to in_ready; outputs hold while stalled.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_gate_pipe_if.slave   io_bus
);
    logic                    r_s1_v;
    logic [2:0]              r_s1_op;
    logic [N_IN*WIDTH-1:0]   r_s1_dat;
    logic                    r_s2_v;
    logic [WIDTH-1:0]        r_s2_dat;
    logic                    r_s2_zero;
    logic                    r_s2_err;
    logic [CNT_W-1:0]        r_done_cnt;

    logic                    w_s2_adv;
    logic                    w_s1_adv;
    logic                    w_in_xfer;
    logic                    w_out_xfer;
    logic [WIDTH-1:0]        w_and;
    logic [WIDTH-1:0]        w_or;
    logic [WIDTH-1:0]        w_xor;
    logic [WIDTH-1:0]        w_res;
    logic                    w_err;

    assign w_s2_adv   = !r_s2_v || io_bus.out_ready;
    assign w_s1_adv   = !r_s1_v || w_s2_adv;
    assign w_in_xfer  = io_bus.in_valid && w_s1_adv;
    assign w_out_xfer = r_s2_v && io_bus.out_ready;

    always_comb begin
        w_and = '1;
        w_or  = '0;
        w_xor = '0;
        for (int k = 0; k < N_IN; k++) begin
            w_and = w_and & r_s1_dat[k*WIDTH +: WIDTH];
            w_or  = w_or  | r_s1_dat[k*WIDTH +: WIDTH];
            w_xor = w_xor ^ r_s1_dat[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (r_s1_op)
            3'b000:  w_res = w_and;
            3'b001:  w_res = w_or;
            3'b010:  w_res = w_xor;
            3'b011:  w_res = ~w_and;
            3'b100:  w_res = ~w_or;
            3'b101:  w_res = ~w_xor;
            3'b110:  w_res = r_s1_dat[WIDTH-1:0];
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v     <= 1'b0;
            r_s1_op    <= '0;
            r_s1_dat   <= '0;
            r_s2_v     <= 1'b0;
            r_s2_dat   <= '0;
            r_s2_zero  <= 1'b0;
            r_s2_err   <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_v <= io_bus.in_valid;
            end
            if (w_in_xfer) begin
                r_s1_op  <= io_bus.in_op;
                r_s1_dat <= io_bus.in_data;
            end
            if (w_s2_adv) begin
                r_s2_v <= r_s1_v;
            end
            // Result regs only move on a real load so out_data keeps its last value across bubbles.
            if (w_s2_adv && r_s1_v) begin
                r_s2_dat  <= w_res;
                r_s2_zero <= (w_res == '0);
                r_s2_err  <= w_err;
            end
            if (w_out_xfer && !(&r_done_cnt)) begin
                r_done_cnt <= r_done_cnt + 1'b1;
            end
        end
    end

    assign io_bus.in_ready  = w_s1_adv;
    assign io_bus.out_valid = r_s2_v;
    assign io_bus.out_data  = r_s2_dat;
    assign io_bus.out_zero  = r_s2_zero;
    assign io_bus.out_err   = r_s2_err;
    assign io_bus.done_cnt  = r_done_cnt;
endmodule
